operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width; only 32 is supported.
REQ-002 The block SHALL have clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_pc (input, 32): the fetch-side handshake, instruction and its PC.
REQ-005 The block SHALL have rs1_addr and rs2_addr, output, 5 bits each: combinational read addresses to the register file, taken from in_instr[19:15] and in_instr[24:20].
REQ-006 The block SHALL have rs1_data and rs2_data, input, 32 bits each: combinational read data from the register file.
REQ-007 The block SHALL have wb_we (input, 1), wb_rd (input, 5) and wb_data (input, 32): the writeback port, which also drives the register file write port.
REQ-008 The block SHALL have flush, input, 1 bit: a synchronous pipeline cancel from downstream.
REQ-009 The block SHALL have out_valid (output, 1) and out_ready (input, 1): the execute-side handshake.
REQ-010 The block SHALL have outputs out_pc (32), out_rs1_val (32), out_rs2_val (32), out_imm (32), out_rd (5), out_opcode (7), out_funct3 (3), out_funct7b5 (1) and out_illegal (1), all registered.

Function
REQ-011 The block SHALL decode these opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; any other opcode SHALL set out_illegal=1.
REQ-012 Destination writes: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP SHALL write rd, and only when rd!=0.
REQ-013 rs1 SHALL be used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP; rs2 SHALL be used by BRANCH, STORE and OP; illegal instructions SHALL use no source and write no destination.
REQ-014 out_imm SHALL be sign-extended by format: I (JALR, LOAD, OP-IMM), S, B, U or J; 0 for OP and illegal instructions.
REQ-015 Bypass: when wb_we=1, wb_rd!=0 and wb_rd equals a used rs, the captured operand SHALL be wb_data instead of rsN_data.
REQ-016 A source address of 0 SHALL yield operand 0; unused sources SHALL capture 0.
REQ-017 Scoreboard: a 32-bit pending vector, one bit per register, with bit 0 always 0.
REQ-018 On capture of a destination-writing instruction, pending[rd] SHALL be set.
REQ-019 When wb_we=1 and wb_rd!=0, pending[wb_rd] SHALL be cleared.
REQ-020 If a capture sets and writeback clears the same bit in one cycle, the set SHALL win.
REQ-021 hazard SHALL be 1 when a used rs, or the written rd (WAW), has its pending bit set and is not cleared by writeback in the same cycle.
REQ-022 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-023 Capture SHALL occur when in_valid && in_ready: the output registers load and out_valid=1 next cycle.
REQ-024 When there is no capture and out_ready=1, out_valid SHALL go to 0 next cycle.
REQ-025 When out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-026 Flush SHALL clear out_valid and the whole pending vector next cycle and capture nothing; a writeback in the same cycle SHALL be ignored by the scoreboard.
REQ-027 Latency SHALL be 1 cycle from capture to out_valid; throughput SHALL be 1 instruction per cycle with no hazard.

Reset
REQ-028 While rst_n=0: out_valid=0, pending=0 and all out_* data fields=0, with in_ready recomputed combinationally.
REQ-029 Reset assertion mid-stall SHALL discard the held instruction, and the block SHALL restart empty.

Verification
REQ-030 Bench: ADDI x5,x0,7, then ADD x6,x5,x5 back-to-back -> ADD stalls (in_ready=0) until wb_we=1, wb_rd=5; the same-cycle bypass captures out_rs1_val=out_rs2_val=7.
REQ-031 Bench: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0; out_ready=1 -> the next instruction is captured the same edge.
REQ-032 Bench: LUI x1,0x12345 -> out_imm=0x12345000; BEQ with offset -4 -> out_imm=0xFFFFFFFC; SW with offset -1 -> out_imm=0xFFFFFFFF.
REQ-033 Bench: ADDI x0,x0,1 -> pending stays 0; a subsequent instruction using x0 does not stall and captures operand 0.
REQ-034 Bench: pending[5]=1, then flush with wb_we=1, wb_rd=5 -> next cycle pending=0 and out_valid=0, with no capture.
REQ-035 Bench: opcode 1111111 -> out_illegal=1, pending unchanged, no stall regardless of pending bits.

Source files
------------

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: decodes RV32I base opcodes, reads and bypasses source
// operands, tracks in-flight destinations in a scoreboard, and registers the result for execute.
module operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic            legal;
   logic            writes_rd;
   logic            uses_rs1;
   logic            uses_rs2;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            wb_hit;
   logic [31:0]     wb_clr_mask;
   logic            hazard;
   logic            capture;
   logic [31:0]     pending_reg;
   logic [31:0]     pending_next;

   assign opcode   = in_instr[6:0];
   assign rd       = in_instr[11:7];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   always_comb begin
      legal    = 1'b1;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      imm      = '0;
      unique case (opcode)
         OPC_LUI, OPC_AUIPC: imm = {in_instr[31:12], 12'b0};
         OPC_JAL: imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            uses_rs1 = 1'b1;
            imm      = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Branch and store are the only legal opcodes that leave rd unwritten.
   assign writes_rd = legal && (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (rd != 5'd0);

   assign wb_hit      = wb_we && (wb_rd != 5'd0);
   assign wb_clr_mask = wb_hit ? (32'd1 << wb_rd) : 32'd0;

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (uses_rs1 && rs1_addr != 5'd0)
         rs1_val = (wb_hit && wb_rd == rs1_addr) ? wb_data : rs1_data;
      if (uses_rs2 && rs2_addr != 5'd0)
         rs2_val = (wb_hit && wb_rd == rs2_addr) ? wb_data : rs2_data;
   end

   // A pending register retired by this cycle's writeback no longer blocks issue.
   assign hazard = (uses_rs1 && pending_reg[rs1_addr] && !wb_clr_mask[rs1_addr]) ||
                   (uses_rs2 && pending_reg[rs2_addr] && !wb_clr_mask[rs2_addr]) ||
                   (writes_rd && pending_reg[rd] && !wb_clr_mask[rd]);

   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign capture  = in_valid && in_ready;

   always_comb begin
      pending_next = pending_reg & ~wb_clr_mask;
      if (capture && writes_rd)
         pending_next[rd] = 1'b1;
      if (flush)
         pending_next = '0;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending_reg <= '0;
      else
         pending_reg <= pending_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_imm      <= '0;
         out_rd       <= '0;
         out_opcode   <= '0;
         out_funct3   <= '0;
         out_funct7b5 <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_rs1_val  <= rs1_val;
         out_rs2_val  <= rs2_val;
         out_imm      <= imm;
         out_rd       <= writes_rd ? rd : 5'd0;
         out_opcode   <= opcode;
         out_funct3   <= in_instr[14:12];
         out_funct7b5 <= in_instr[30];
         out_illegal  <= !legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
